// File: rtl/ub_read_collector.sv
// Collects unified-buffer read words from two lanes into an output FIFO.
// Admits a read command only when the FIFO can hold every word it returns.
module ub_read_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [5:0]            cmd_addr,
    input  logic [5:0]            cmd_len,
    output logic                  ub_read_start_out,
    output logic [5:0]            ub_read_addr_out,
    output logic [5:0]            ub_num_mem_locations_out,
    input  logic [DATA_WIDTH-1:0] ub_data_1_in,
    input  logic [DATA_WIDTH-1:0] ub_data_2_in,
    input  logic                  ub_valid_1_in,
    input  logic                  ub_valid_2_in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow,
    output logic                  err_unexpected
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COLLECT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OW-1:0]   occ;
    logic [OW-1:0]   space;
    logic [5:0]      words_left;
    logic [5:0]      wl_nxt;
    logic [1:0]      n_push;
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

    logic cmd_fire;
    logic pop;
    logic collect;
    logic want1;
    logic want2;
    logic push1;
    logic push2;
    logic last1;
    logic last2;
    logic finish;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign pop      = out_valid && out_ready;
    assign collect  = (state == COLLECT);

    // Lane 1 precedes lane 2 in address order, so it claims words_left first
    assign want1 = ub_valid_1_in && collect && (words_left != 6'd0);
    assign want2 = ub_valid_2_in && collect && (words_left > 6'(want1));

    // Space counts the slot freed by a same-cycle pop; lane 2 loses first
    assign space  = OW'(FIFO_DEPTH) - occ + OW'(pop);
    assign push1  = want1 && (space != '0);
    assign push2  = want2 && (space > OW'(push1));
    assign n_push = 2'(push1) + 2'(push2);
    assign wl_nxt = words_left - 6'(n_push);

    assign last1  = (words_left == 6'd1);
    assign last2  = ((words_left - 6'(push1)) == 6'd1);
    assign finish = collect && (n_push != 2'd0) && (wl_nxt == 6'd0);

    assign cmd_ready = (state == IDLE)
                    && ((OW'(FIFO_DEPTH) - occ) >= OW'(cmd_len));

    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr][DATA_WIDTH-1:0];
    assign out_last  = out_valid && mem[rd_ptr][DATA_WIDTH];

    assign busy              = (state != IDLE);
    assign ub_read_start_out = (state == ISSUE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_fire && cmd_len != 6'd0) state_nxt = ISSUE;
            ISSUE:   state_nxt = COLLECT;
            COLLECT: if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                    <= IDLE;
            wr_ptr                   <= '0;
            rd_ptr                   <= '0;
            occ                      <= '0;
            words_left               <= '0;
            ub_read_addr_out         <= '0;
            ub_num_mem_locations_out <= '0;
            done                     <= 1'b0;
            err_overflow             <= 1'b0;
            err_unexpected           <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            occ    <= occ + OW'(n_push) - OW'(pop);
            if (cmd_fire) begin
                ub_read_addr_out         <= cmd_addr;
                ub_num_mem_locations_out <= cmd_len;
                words_left               <= cmd_len;
            end else if (collect) begin
                words_left <= wl_nxt;
            end
            done <= (cmd_fire && cmd_len == 6'd0) || finish;
            if ((want1 && !push1) || (want2 && !push2))
                err_overflow <= 1'b1;
            if ((ub_valid_1_in && !want1) || (ub_valid_2_in && !want2))
                err_unexpected <= 1'b1;
        end
    end

    // Storage holds {last, data}; only pointers are reset
    always_ff @(posedge clk) begin
        if (rst && push1)
            mem[wr_ptr] <= {last1, ub_data_1_in};
        if (rst && push2)
            mem[wr_ptr + AW'(push1)] <= {last2, ub_data_2_in};
    end

endmodule

// File: tb/tb_ub_read_collector.sv
// Directed bench for ub_read_collector with an output scoreboard.
// Lanes are driven from a modelled UB where mem[i] = 0x100 + i.
module tb_ub_read_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        ub_read_start_out;
    logic [5:0]  ub_read_addr_out;
    logic [5:0]  ub_num_mem_locations_out;
    logic [15:0] ub_data_1_in;
    logic [15:0] ub_data_2_in;
    logic        ub_valid_1_in;
    logic        ub_valid_2_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err_overflow;
    logic        err_unexpected;

    int n_assert = 0;
    int n_fail   = 0;
    int ub_addr  = 0;
    int rem      = 0;
    logic [16:0] exp_q [$];
    logic [16:0] head;

    always #5 clk = ~clk;

    ub_read_collector #(.DATA_WIDTH(16), .FIFO_DEPTH(64)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .cmd_valid                (cmd_valid),
        .cmd_ready                (cmd_ready),
        .cmd_addr                 (cmd_addr),
        .cmd_len                  (cmd_len),
        .ub_read_start_out        (ub_read_start_out),
        .ub_read_addr_out         (ub_read_addr_out),
        .ub_num_mem_locations_out (ub_num_mem_locations_out),
        .ub_data_1_in             (ub_data_1_in),
        .ub_data_2_in             (ub_data_2_in),
        .ub_valid_1_in            (ub_valid_1_in),
        .ub_valid_2_in            (ub_valid_2_in),
        .out_data                 (out_data),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .out_last                 (out_last),
        .busy                     (busy),
        .done                     (done),
        .err_overflow             (err_overflow),
        .err_unexpected           (err_unexpected)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score any pop at the negedge, then return just after posedge
    task automatic step();
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_extra observed=%h expected=none",
                       {out_last, out_data});
            end
            if (exp_q.size() != 0) begin
                head = exp_q.pop_front();
                chk("sb_word", {15'd0, out_last, out_data}, {15'd0, head});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [5:0] a, input logic [5:0] n);
        cmd_addr  = a;
        cmd_len   = n;
        cmd_valid = 1'b1;
        ub_addr   = int'(a);
        rem       = int'(n);
        chk("cmd_ready_pre", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("start_pulse", {31'd0, ub_read_start_out}, 32'd1);
        chk("busy_issue", {31'd0, busy}, 32'd1);
        chk("addr_out", {26'd0, ub_read_addr_out}, {26'd0, a});
        chk("len_out", {26'd0, ub_num_mem_locations_out}, {26'd0, n});
        step();
        chk("start_off", {31'd0, ub_read_start_out}, 32'd0);
    endtask

    // Drive one UB cycle; each valid lane takes the next linear address
    task automatic feed(input logic v1, input logic v2);
        ub_valid_1_in = v1;
        ub_valid_2_in = v2;
        if (v1) begin
            ub_data_1_in = 16'(16'h100 + ub_addr);
            exp_q.push_back({rem == 1, ub_data_1_in});
            ub_addr++;
            rem--;
        end
        if (v2) begin
            ub_data_2_in = 16'(16'h100 + ub_addr);
            exp_q.push_back({rem == 1, ub_data_2_in});
            ub_addr++;
            rem--;
        end
        step();
        ub_valid_1_in = 1'b0;
        ub_valid_2_in = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain_left", exp_q.size(), 32'd0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst           = 1'b0;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        ub_data_1_in  = '0;
        ub_data_2_in  = '0;
        ub_valid_1_in = 1'b0;
        ub_valid_2_in = 1'b0;
        out_ready     = 1'b1;
        repeat (3) step();

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_start", {31'd0, ub_read_start_out}, 32'd0);
        chk("rst_addr", {26'd0, ub_read_addr_out}, 32'd0);
        chk("rst_len", {26'd0, ub_num_mem_locations_out}, 32'd0);
        chk("rst_errs", {30'd0, err_overflow, err_unexpected}, 32'd0);
        rst = 1'b1;
        step();

        // addr 4, len 6, full-width lanes
        issue_cmd(6'd4, 6'd6);
        chk("busy_collect", {31'd0, busy}, 32'd1);
        feed(1'b1, 1'b1);
        feed(1'b1, 1'b1);
        chk("done_early", {31'd0, done}, 32'd0);
        feed(1'b1, 1'b1);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        step();
        chk("done_clear", {31'd0, done}, 32'd0);
        drain();

        // odd length with partial lane cycles
        issue_cmd(6'd10, 6'd5);
        feed(1'b1, 1'b0);
        feed(1'b1, 1'b1);
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b1);
        chk("odd_done", {31'd0, done}, 32'd1);
        drain();
        chk("odd_errs", {30'd0, err_overflow, err_unexpected}, 32'd0);

        // zero length command
        cmd_addr  = 6'd9;
        cmd_len   = 6'd0;
        cmd_valid = 1'b1;
        chk("zl_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("zl_start", {31'd0, ub_read_start_out}, 32'd0);
        chk("zl_busy", {31'd0, busy}, 32'd0);
        chk("zl_done", {31'd0, done}, 32'd1);
        chk("zl_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("zl_done_clr", {31'd0, done}, 32'd0);
        chk("zl_start2", {31'd0, ub_read_start_out}, 32'd0);
        chk("zl_valid2", {31'd0, out_valid}, 32'd0);

        // back-pressure: 60 words parked, then a len 8 command must wait
        out_ready = 1'b0;
        issue_cmd(6'd0, 6'd60);
        for (int i = 0; i < 30; i++) feed(1'b1, 1'b1);
        step();
        cmd_len = 6'd8;
        chk("bp_not_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bp_hold_a", {16'd0, out_data}, {16'd0, exp_q[0][15:0]});
        step();
        chk("bp_hold_b", {16'd0, out_data}, {16'd0, exp_q[0][15:0]});
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        chk("bp_ready", {31'd0, cmd_ready}, 32'd1);
        issue_cmd(6'd32, 6'd8);
        for (int i = 0; i < 4; i++) feed(1'b1, 1'b1);
        step();
        chk("full_not_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bp_no_ovf", {31'd0, err_overflow}, 32'd0);
        drain();
        chk("bp_unexp", {31'd0, err_unexpected}, 32'd0);

        // stray lane valid in IDLE
        ub_valid_1_in = 1'b1;
        ub_data_1_in  = 16'hdead;
        step();
        ub_valid_1_in = 1'b0;
        chk("stray_err", {31'd0, err_unexpected}, 32'd1);
        chk("stray_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("stray_sticky", {31'd0, err_unexpected}, 32'd1);

        // reset in the middle of a len 20 collect
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_clr_err", {31'd0, err_unexpected}, 32'd0);
        out_ready = 1'b0;
        issue_cmd(6'd0, 6'd20);
        for (int i = 0; i < 3; i++) feed(1'b1, 1'b1);
        chk("mid_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b0;
        step();
        exp_q.delete();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b1;
        ub_valid_1_in = 1'b1;
        ub_valid_2_in = 1'b1;
        step();
        ub_valid_1_in = 1'b0;
        ub_valid_2_in = 1'b0;
        chk("trail_err", {31'd0, err_unexpected}, 32'd1);
        chk("trail_valid", {31'd0, out_valid}, 32'd0);
        chk("trail_ovf", {31'd0, err_overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
